// File: rtl/memory_sequencer_pkg.sv
// Shared encodings for the memory sequencer: op codes, datapath selects,
// FSM state encoding and stack bounds.
package memseq_pkg;

    typedef enum logic [2:0] {
        OP_FETCH = 3'd0,
        OP_PUSH  = 3'd1,
        OP_POP   = 3'd2,
        OP_CALL  = 3'd3,
        OP_RET   = 3'd4
    } op_t;

    typedef enum logic [1:0] {
        MSRC_MARY    = 2'd0,
        MSRC_SHELLEY = 2'd1,
        MSRC_RA      = 2'd2,
        MSRC_COMP    = 2'd3
    } mem_src_t;

    typedef enum logic [2:0] {
        MDST_PC       = 3'd0,
        MDST_SP_PLUS2 = 3'd4,
        MDST_SP       = 3'd5
    } mem_dst_t;

    typedef enum logic [2:0] {
        PCSRC_HOLD   = 3'd0,
        PCSRC_PLUS2  = 3'd1,
        PCSRC_IMM    = 3'd3,
        PCSRC_MEMVAL = 3'd4
    } pc_src_t;

    typedef enum logic [2:0] {
        SPSRC_HOLD   = 3'd0,
        SPSRC_PLUS2  = 3'd1,
        SPSRC_MINUS2 = 3'd2
    } sp_src_t;

    typedef enum logic [3:0] {
        S_INIT     = 4'd0,
        S_IDLE     = 4'd1,
        S_FETCH    = 4'd2,
        S_PC_INC   = 4'd3,
        S_PUSH_WR  = 4'd4,
        S_PUSH_SP  = 4'd5,
        S_POP_ADR  = 4'd6,
        S_POP_RD   = 4'd7,
        S_POP_SP   = 4'd8,
        S_CALL_WR  = 4'd9,
        S_CALL_SP  = 4'd10,
        S_CALL_JMP = 4'd11,
        S_RET_ADR  = 4'd12,
        S_RET_RD   = 4'd13,
        S_RET_SP   = 4'd14,
        S_DONE     = 4'd15
    } state_t;

    localparam logic [15:0] SP_MAX = 16'hFFFE;
    localparam logic [15:0] SP_MIN = 16'h0000;

    // Stack overflow/underflow or an illegal op code sends the request down the error path.
    function automatic logic op_rejected(input logic [2:0] op, input logic [15:0] sp);
        case (op)
            OP_FETCH:         return 1'b0;
            OP_PUSH, OP_CALL: return (sp == SP_MAX);
            OP_POP, OP_RET:   return (sp == SP_MIN);
            default:          return 1'b1;
        endcase
    endfunction

    // First state of a legal operation.
    function automatic state_t first_state(input logic [2:0] op);
        case (op)
            OP_FETCH: return S_FETCH;
            OP_PUSH:  return S_PUSH_WR;
            OP_POP:   return S_POP_ADR;
            OP_CALL:  return S_CALL_WR;
            OP_RET:   return S_RET_ADR;
            default:  return S_DONE;
        endcase
    endfunction

endpackage

// File: rtl/memory_sequencer.sv
// Memory sequencer: turns single operation requests (FETCH/PUSH/POP/CALL/RET)
// into a timed sequence of control strobes for the PC/SP/memory block.
module memory_sequencer
    import memseq_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [2:0]  req_op,
    output logic        req_ready,
    output logic        done,
    output logic        err,
    output logic [15:0] pop_data,
    input  logic [15:0] sp_in,
    input  logic [15:0] mem_val_in,
    output logic        MemWrite,
    output logic        PCWrite,
    output logic        SPWrite,
    output logic        InstWrite,
    output logic        PCReset,
    output logic        SPReset,
    output logic [1:0]  MemSrc,
    output logic [2:0]  MemDst,
    output logic [2:0]  PCSrc,
    output logic [2:0]  SPSrc
);

    state_t      state;
    logic        err_q;
    logic [15:0] pop_q;

    // State register; err_q remembers whether the accepted request was rejected.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_INIT;
            err_q <= 1'b0;
        end else begin
            case (state)
                S_INIT:     state <= S_IDLE;
                S_IDLE: begin
                    if (req_valid) begin
                        if (op_rejected(req_op, sp_in)) begin
                            state <= S_DONE;
                            err_q <= 1'b1;
                        end else begin
                            state <= first_state(req_op);
                            err_q <= 1'b0;
                        end
                    end
                end
                S_FETCH:    state <= S_PC_INC;
                S_PC_INC:   state <= S_DONE;
                S_PUSH_WR:  state <= S_PUSH_SP;
                S_PUSH_SP:  state <= S_DONE;
                S_POP_ADR:  state <= S_POP_RD;
                S_POP_RD:   state <= S_POP_SP;
                S_POP_SP:   state <= S_DONE;
                S_CALL_WR:  state <= S_CALL_SP;
                S_CALL_SP:  state <= S_CALL_JMP;
                S_CALL_JMP: state <= S_DONE;
                S_RET_ADR:  state <= S_RET_RD;
                S_RET_RD:   state <= S_RET_SP;
                S_RET_SP:   state <= S_DONE;
                S_DONE:     state <= S_IDLE;
                default:    state <= S_INIT;
            endcase
        end
    end

    // Captures the word returned by memory one cycle after the address was presented.
    always_ff @(posedge clock) begin
        if (reset) begin
            pop_q <= '0;
        end else if (state == S_POP_RD || state == S_RET_RD) begin
            pop_q <= mem_val_in;
        end
    end

    // Reset is applied to the outputs directly so they are quiet from the very
    // first reset cycle, before the state register has been forced to INIT.
    assign pop_data = reset ? '0 : pop_q;

    // Per-state control decode; anything not driven stays at 0.
    always_comb begin
        req_ready = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        MemWrite  = 1'b0;
        PCWrite   = 1'b0;
        SPWrite   = 1'b0;
        InstWrite = 1'b0;
        PCReset   = 1'b0;
        SPReset   = 1'b0;
        MemSrc    = MSRC_MARY;
        MemDst    = MDST_PC;
        PCSrc     = PCSRC_HOLD;
        SPSrc     = SPSRC_HOLD;
        if (!reset) begin
            case (state)
                S_INIT: begin
                    PCWrite = 1'b1;
                    SPWrite = 1'b1;
                    PCReset = 1'b1;
                    SPReset = 1'b1;
                end
                S_IDLE:    req_ready = 1'b1;
                S_FETCH: begin
                    MemDst    = MDST_PC;
                    InstWrite = 1'b1;
                end
                S_PC_INC: begin
                    PCWrite = 1'b1;
                    PCSrc   = PCSRC_PLUS2;
                end
                S_PUSH_WR: begin
                    MemWrite = 1'b1;
                    MemDst   = MDST_SP_PLUS2;
                    MemSrc   = MSRC_SHELLEY;
                end
                S_PUSH_SP, S_CALL_SP: begin
                    SPWrite = 1'b1;
                    SPSrc   = SPSRC_PLUS2;
                end
                S_POP_ADR, S_POP_RD, S_RET_ADR: MemDst = MDST_SP;
                S_POP_SP, S_RET_SP: begin
                    SPWrite = 1'b1;
                    SPSrc   = SPSRC_MINUS2;
                end
                S_CALL_WR: begin
                    MemWrite = 1'b1;
                    MemDst   = MDST_SP_PLUS2;
                    MemSrc   = MSRC_RA;
                end
                S_CALL_JMP: begin
                    PCWrite = 1'b1;
                    PCSrc   = PCSRC_IMM;
                end
                S_RET_RD: begin
                    MemDst  = MDST_SP;
                    PCWrite = 1'b1;
                    PCSrc   = PCSRC_MEMVAL;
                end
                S_DONE: begin
                    done = 1'b1;
                    err  = err_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_sequencer.sv
// Directed bench for memory_sequencer with a behavioural PC/SP/memory block.
module tb_memory_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic [2:0]  req_op = 3'd0;
    logic        req_ready, done, err;
    logic [15:0] pop_data, sp_in, mem_val_in;
    logic        MemWrite, PCWrite, SPWrite, InstWrite, PCReset, SPReset;
    logic [1:0]  MemSrc;
    logic [2:0]  MemDst, PCSrc, SPSrc;

    memory_sequencer dut (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_op(req_op),
        .req_ready(req_ready), .done(done), .err(err), .pop_data(pop_data),
        .sp_in(sp_in), .mem_val_in(mem_val_in),
        .MemWrite(MemWrite), .PCWrite(PCWrite), .SPWrite(SPWrite), .InstWrite(InstWrite),
        .PCReset(PCReset), .SPReset(SPReset),
        .MemSrc(MemSrc), .MemDst(MemDst), .PCSrc(PCSrc), .SPSrc(SPSrc)
    );

    always #5 clock = ~clock;

    // Behavioural PC/SP/memory block
    logic [15:0] pc, sp_q, mem_val, model_addr, src_val;
    logic [15:0] mem [0:63];
    logic [15:0] mary_data = 16'h1111, shelley_data = 16'h0000;
    logic [15:0] ra_data = 16'h0000, comp_data = 16'h3333, imm_data = 16'h0000;
    logic        sp_force_en = 1'b0;
    logic [15:0] sp_force = 16'h0000;
    int strobe_cnt = 0, fetch_cnt = 0, proto_bad = 0;
    int total = 0, bad = 0;

    assign sp_in      = sp_force_en ? sp_force : sp_q;
    assign mem_val_in = mem_val;

    always_comb begin
        case (MemDst)
            3'd4:    model_addr = sp_in + 16'd2;
            3'd5:    model_addr = sp_in;
            default: model_addr = pc;
        endcase
        case (MemSrc)
            2'd0:    src_val = mary_data;
            2'd1:    src_val = shelley_data;
            2'd2:    src_val = ra_data;
            default: src_val = comp_data;
        endcase
    end

    always @(posedge clock) begin
        if (MemWrite) mem[model_addr[6:1]] <= src_val;
        mem_val <= mem[model_addr[6:1]];
        if (PCReset) pc <= '0;
        else if (PCWrite) begin
            case (PCSrc)
                3'd1:    pc <= pc + 16'd2;
                3'd3:    pc <= imm_data;
                3'd4:    pc <= mem_val;
                default: pc <= pc;
            endcase
        end
        if (SPReset) sp_q <= '0;
        else if (SPWrite) begin
            case (SPSrc)
                3'd1:    sp_q <= sp_q + 16'd2;
                3'd2:    sp_q <= sp_q - 16'd2;
                default: sp_q <= sp_q;
            endcase
        end
        if (MemWrite || PCWrite || SPWrite) strobe_cnt = strobe_cnt + 1;
        if (InstWrite) fetch_cnt = fetch_cnt + 1;
        if (MemWrite && InstWrite) proto_bad = proto_bad + 1;
        if (PCWrite && SPWrite && !PCReset) proto_bad = proto_bad + 1;
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    // Waits for IDLE, issues one request, returns cycles from acceptance to done.
    task automatic run_op(input logic [2:0] op, output int lat, output logic e);
        int guard;
        guard = 0;
        while (!req_ready && guard < 50) begin tick; guard++; end
        req_valid = 1'b1;
        req_op    = op;
        tick;
        req_valid = 1'b0;
        lat = 1;
        while (!done && lat < 20) begin tick; lat++; end
        e = err;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick; tick;
        total++;
        if ({MemWrite, PCWrite, SPWrite, InstWrite, PCReset, SPReset, done, err, req_ready} !== 9'b0) begin
            bad++; $display("FAIL reset_outputs got=%b exp=0", {MemWrite, PCWrite, SPWrite, InstWrite, PCReset, SPReset, done, err, req_ready});
        end
        total++;
        if (pop_data !== 16'h0000) begin bad++; $display("FAIL reset_pop_data got=%h exp=0000", pop_data); end
        reset = 1'b0;
        #1;
        total++;
        if ({PCWrite, SPWrite, PCReset, SPReset, req_ready} !== 5'b11110) begin
            bad++; $display("FAIL init_cycle got=%b exp=11110", {PCWrite, SPWrite, PCReset, SPReset, req_ready});
        end
        tick;
        total++;
        if ({req_ready, PCWrite, SPWrite} !== 3'b100) begin
            bad++; $display("FAIL idle_after_init got=%b exp=100", {req_ready, PCWrite, SPWrite});
        end
        total++;
        if ({pc, sp_q} !== 32'h0) begin bad++; $display("FAIL reset_pc_sp got=%h exp=00000000", {pc, sp_q}); end
    endtask

    task automatic test_push;
        int lat; logic e;
        shelley_data = 16'h0007;
        run_op(3'd1, lat, e);
        total++;
        if (lat !== 3 || e !== 1'b0) begin bad++; $display("FAIL push_done got lat=%0d err=%b exp lat=3 err=0", lat, e); end
        tick;
        total++;
        if ({mem[1], sp_q} !== {16'h0007, 16'h0002}) begin bad++; $display("FAIL push_result got mem2=%h sp=%h exp 0007 0002", mem[1], sp_q); end
        total++;
        if (req_ready !== 1'b1) begin bad++; $display("FAIL push_ready_after got=%b exp=1", req_ready); end
    endtask

    task automatic test_pop;
        int lat; logic e;
        run_op(3'd2, lat, e);
        total++;
        if (lat !== 4 || e !== 1'b0) begin bad++; $display("FAIL pop_done got lat=%0d err=%b exp lat=4 err=0", lat, e); end
        total++;
        if ({pop_data, sp_q} !== {16'h0007, 16'h0000}) begin bad++; $display("FAIL pop_result got pop=%h sp=%h exp 0007 0000", pop_data, sp_q); end
    endtask

    task automatic test_call_ret;
        int lat; logic e;
        ra_data = 16'h0040; imm_data = 16'h0100;
        run_op(3'd3, lat, e);
        total++;
        if (lat !== 4 || e !== 1'b0) begin bad++; $display("FAIL call_done got lat=%0d err=%b exp lat=4 err=0", lat, e); end
        total++;
        if ({mem[1], sp_q, pc} !== {16'h0040, 16'h0002, 16'h0100}) begin
            bad++; $display("FAIL call_result got mem2=%h sp=%h pc=%h exp 0040 0002 0100", mem[1], sp_q, pc);
        end
        run_op(3'd4, lat, e);
        total++;
        if (lat !== 4 || e !== 1'b0) begin bad++; $display("FAIL ret_done got lat=%0d err=%b exp lat=4 err=0", lat, e); end
        total++;
        if ({pc, sp_q, pop_data} !== {16'h0040, 16'h0000, 16'h0040}) begin
            bad++; $display("FAIL ret_result got pc=%h sp=%h pop=%h exp 0040 0000 0040", pc, sp_q, pop_data);
        end
    endtask

    task automatic test_fetch;
        int lat, f0; logic e;
        f0 = fetch_cnt;
        run_op(3'd0, lat, e);
        total++;
        if (lat !== 3 || e !== 1'b0) begin bad++; $display("FAIL fetch_done got lat=%0d err=%b exp lat=3 err=0", lat, e); end
        total++;
        if (pc !== 16'h0042 || fetch_cnt - f0 !== 1) begin
            bad++; $display("FAIL fetch_result got pc=%h inst_writes=%0d exp 0042 1", pc, fetch_cnt - f0);
        end
    endtask

    task automatic test_underflow;
        int lat, s0; logic e;
        s0 = strobe_cnt;
        run_op(3'd2, lat, e);
        total++;
        if (lat !== 1 || e !== 1'b1) begin bad++; $display("FAIL pop_underflow got lat=%0d err=%b exp lat=1 err=1", lat, e); end
        run_op(3'd4, lat, e);
        total++;
        if (lat !== 1 || e !== 1'b1) begin bad++; $display("FAIL ret_underflow got lat=%0d err=%b exp lat=1 err=1", lat, e); end
        tick;
        total++;
        if (strobe_cnt - s0 !== 0 || pop_data !== 16'h0040) begin
            bad++; $display("FAIL underflow_quiet got strobes=%0d pop=%h exp 0 0040", strobe_cnt - s0, pop_data);
        end
    endtask

    task automatic test_overflow;
        int lat, s0; logic e;
        s0 = strobe_cnt;
        sp_force_en = 1'b1; sp_force = 16'hFFFE;
        run_op(3'd1, lat, e);
        total++;
        if (lat !== 1 || e !== 1'b1) begin bad++; $display("FAIL push_overflow got lat=%0d err=%b exp lat=1 err=1", lat, e); end
        run_op(3'd3, lat, e);
        total++;
        if (lat !== 1 || e !== 1'b1) begin bad++; $display("FAIL call_overflow got lat=%0d err=%b exp lat=1 err=1", lat, e); end
        tick;
        sp_force_en = 1'b0;
        total++;
        if (strobe_cnt - s0 !== 0) begin bad++; $display("FAIL overflow_quiet got strobes=%0d exp 0", strobe_cnt - s0); end
    endtask

    task automatic test_illegal;
        int lat; logic e;
        for (int op = 5; op < 8; op++) begin
            run_op(3'(op), lat, e);
            total++;
            if (lat !== 1 || e !== 1'b1) begin bad++; $display("FAIL illegal_op%0d got lat=%0d err=%b exp lat=1 err=1", op, lat, e); end
        end
    endtask

    task automatic test_ignore;
        shelley_data = 16'h0055;
        while (!req_ready) tick;
        req_valid = 1'b1; req_op = 3'd1;
        tick;
        req_op = 3'd2;
        tick; tick;
        req_valid = 1'b0;
        total++;
        if (done !== 1'b1) begin bad++; $display("FAIL ignore_done got=%b exp=1", done); end
        tick; tick;
        total++;
        if ({req_ready, sp_q, mem[1]} !== {1'b1, 16'h0002, 16'h0055}) begin
            bad++; $display("FAIL ignore_no_queue got ready=%b sp=%h mem2=%h exp 1 0002 0055", req_ready, sp_q, mem[1]);
        end
    endtask

    task automatic test_reset_mid;
        while (!req_ready) tick;
        req_valid = 1'b1; req_op = 3'd3;
        tick;
        req_valid = 1'b0;
        tick;
        total++;
        if ({SPWrite, SPSrc} !== {1'b1, 3'd1}) begin bad++; $display("FAIL call_sp_state got=%b exp=1001", {SPWrite, SPSrc}); end
        reset = 1'b1;
        tick;
        total++;
        if ({MemWrite, PCWrite, SPWrite, InstWrite, PCReset, SPReset, req_ready} !== 7'b0) begin
            bad++; $display("FAIL abort_quiet got=%b exp=0", {MemWrite, PCWrite, SPWrite, InstWrite, PCReset, SPReset, req_ready});
        end
        reset = 1'b0;
        #1;
        total++;
        if ({PCReset, SPReset, req_ready} !== 3'b110) begin bad++; $display("FAIL abort_init got=%b exp=110", {PCReset, SPReset, req_ready}); end
        tick;
        total++;
        if ({req_ready, pc, sp_q} !== {1'b1, 32'h0}) begin
            bad++; $display("FAIL abort_recover got ready=%b pc=%h sp=%h exp 1 0000 0000", req_ready, pc, sp_q);
        end
    endtask

    task automatic test_back_to_back;
        int lat, bad_lat; logic e;
        bad_lat = 0;
        for (int k = 0; k < 15; k++) begin
            shelley_data = 16'(k);
            run_op(3'd1, lat, e);
            if (lat != 3 || e != 1'b0) bad_lat++;
        end
        tick;
        total++;
        if (bad_lat !== 0 || sp_q !== 16'd30) begin bad++; $display("FAIL b2b_sp got sp=%0d bad_lat=%0d exp 30 0", sp_q, bad_lat); end
        for (int k = 1; k <= 15; k++) begin
            total++;
            if (mem[k] !== 16'(k - 1)) begin bad++; $display("FAIL b2b_mem%0d got=%h exp=%h", 2 * k, mem[k], 16'(k - 1)); end
        end
    endtask

    initial begin
        test_reset;
        test_push;
        test_pop;
        test_call_ret;
        test_fetch;
        test_underflow;
        test_overflow;
        test_illegal;
        test_ignore;
        test_reset_mid;
        test_back_to_back;
        total++;
        if (proto_bad !== 0) begin bad++; $display("FAIL strobe_exclusion got=%0d exp=0", proto_bad); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
